kernel_window_ctrl: RTL and testbench
=====================================

Name: kernel_window_ctrl

Overview:
Frame-level sequencer for the pixel-to-kernel datapath (line buffers plus kernel shift registers). It counts column and row for each accepted pixel and drives a single shift enable to the datapath. It primes the first KERNEL_H-1 rows, then raises window-valid only for fully in-image KERNEL_W x KERNEL_H windows. It applies downstream backpressure to the pixel source and signals end of frame.

Parameters:
IMG_WIDTH, 64, pixels per row (>= KERNEL_W)
IMG_HEIGHT, 128, rows per frame (>= KERNEL_H)
KERNEL_W, 3, window width in pixels (>= 1)
KERNEL_H, 3, window height in rows (>= 1)
COL_W, $clog2(IMG_WIDTH), column counter width (derived)
ROW_W, $clog2(IMG_HEIGHT), row counter width (derived)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; arms the block for one frame (ignored unless IDLE)
pix_valid  in  1  upstream pixel valid
pix_ready  out  1  upstream pixel ready
shift_en  out  1  datapath advance (= pix_valid && pix_ready)
win_valid  out  1  window in datapath registers is complete and valid
win_ready  in  1  downstream accepts window
win_col  out  COL_W  column of window's bottom-right pixel
win_row  out  ROW_W  row of window's bottom-right pixel
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse, frame fully drained

Behaviour:
- Reset (rst=0, async): state=IDLE; col=0, row=0; win_valid=0, win_col=0, win_row=0, frame_done=0. pix_ready and shift_en evaluate to 0.
- States: IDLE, PRIME, RUN, DRAIN.
- IDLE: pix_ready=0. On start, go to PRIME (or to RUN if KERNEL_H==1), clearing col and row.
- PRIME: pix_ready=1, win_valid stays 0. On each shift_en, col increments; when col wraps from IMG_WIDTH-1 to 0, row increments. When the beat at col=IMG_WIDTH-1, row=KERNEL_H-2 is accepted, go to RUN.
- RUN: pix_ready = !(win_valid && !win_ready). This is a single-entry stall with no skid, giving full throughput while win_ready=1.
- RUN, window launch: an accepted beat is eligible when col >= KERNEL_W-1. On the next cycle win_valid=1, and win_col/win_row hold that beat's col/row.
- RUN, window hold: win_valid holds until a cycle with win_ready=1. It then clears unless a new eligible beat is accepted in that same cycle, in which case it stays 1 with updated coordinates.
- RUN, row start: non-eligible beats (col < KERNEL_W-1) still shift the datapath, but do not set win_valid. A beat accepted while win_valid && win_ready leaves win_valid=0 next cycle.
- Last beat: when col=IMG_WIDTH-1, row=IMG_HEIGHT-1 is accepted, go to DRAIN; col and row return to 0.
- DRAIN: pix_ready=0. Once win_valid=0 (final window accepted), pulse frame_done for one cycle and go to IDLE in the same cycle.
- Latency: one cycle from accepting the completing pixel to win_valid.
- Frame totals: IMG_WIDTH*IMG_HEIGHT shift_en pulses and (IMG_WIDTH-KERNEL_W+1)*(IMG_HEIGHT-KERNEL_H+1) windows.
- start outside IDLE: ignored. pix_valid in IDLE or DRAIN: not accepted.
- Reset mid-frame: everything returns to its reset value immediately; no frame_done is issued.
- Counters: compare in native width; col wraps exactly at IMG_WIDTH-1 (non-power-of-two widths must work).
- win_valid must not depend combinationally on win_ready. pix_ready may.

Decomposition:
- Shared package (hog_pkg): state encodings (IDLE=0, PRIME=1, RUN=2, DRAIN=3) and default image/kernel dimension constants for use by the datapath.
- One sub-module is natural: pixel_pos_counter (col/row counters with wrap, last-in-row and last-in-frame flags; inputs clk, rst, clr, inc). The FSM and window-valid register stay in kernel_window_ctrl.

Test Plan:
1. IMG 8x6, K 3x3, pix_valid=1, win_ready=1 after start → 16 prime beats with win_valid=0. Then 24 windows; first has win_col=2, win_row=2; last has win_col=7, win_row=5. frame_done one cycle after the last window; 48 shift_en total.
2. Same configuration, win_ready=0 for 5 cycles at the first window → pix_ready=0 and shift_en=0 for those cycles; win_valid, win_col=2, win_row=2 stable; resumes without loss or duplicate (24 windows total).
3. Random pix_valid/win_ready (50%), IMG 10x7, K 3x3 → exactly 40 windows, coordinates in raster order, no win_valid while col<2 or row<2, 70 shift_en.
4. K 1x1, IMG 4x2 → no PRIME; 8 windows at coordinates (0,0) to (3,1); frame_done pulses once.
5. Assert rst low mid-RUN at row 3, col 4 → next cycle all outputs at reset values, state IDLE, no frame_done. A new start then runs a full clean frame.
6. Pulse start during RUN, and hold pix_valid=1 in IDLE/DRAIN → start ignored; pix_ready=0 and no shift_en outside PRIME/RUN.

Source files
------------

// File: rtl/kernel_window_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kernel_window_ctrl_pkg
// Description : Shared state encoding and default image/kernel dimensions
//               for the pixel-to-kernel window sequencer and its datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package kernel_window_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int c_IMG_WIDTH  = 64;
    localparam int c_IMG_HEIGHT = 128;
    localparam int c_KERNEL_W   = 3;
    localparam int c_KERNEL_H   = 3;

    // Counter width that stays legal for a degenerate one-pixel dimension.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : kernel_window_ctrl_pkg
`default_nettype wire

// File: rtl/kernel_window_ctrl_pixel_pos_counter.sv
`default_nettype none
// ============================================================================
// Module      : kernel_window_ctrl_pixel_pos_counter
// Description : Raster column/row position of the next pixel, with
//               last-in-row and last-in-frame flags.
// Revision    : 1.0 - initial release
// ============================================================================
module kernel_window_ctrl_pixel_pos_counter
    import kernel_window_ctrl_pkg::*;
#(
    parameter int IMG_WIDTH  = c_IMG_WIDTH,
    parameter int IMG_HEIGHT = c_IMG_HEIGHT,
    parameter int COL_W      = cnt_width(IMG_WIDTH),
    parameter int ROW_W      = cnt_width(IMG_HEIGHT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [COL_W-1:0] o_col,
    output logic [ROW_W-1:0] o_row,
    output logic             o_last_col,
    output logic             o_last_frame
);

    localparam logic [COL_W-1:0] c_LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] c_LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             w_last_col;
    logic             w_last_row;

    assign w_last_col = (r_col == c_LAST_COL);
    assign w_last_row = (r_row == c_LAST_ROW);

    // Explicit wrap compares keep non-power-of-two dimensions exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_inc) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_col        = r_col;
    assign o_row        = r_row;
    assign o_last_col   = w_last_col;
    assign o_last_frame = w_last_col && w_last_row;

endmodule : kernel_window_ctrl_pixel_pos_counter
`default_nettype wire

// File: rtl/kernel_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : kernel_window_ctrl
// Description : Frame sequencer for the line-buffer / kernel-shift datapath:
//               primes rows, flags complete windows, applies backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module kernel_window_ctrl
    import kernel_window_ctrl_pkg::*;
#(
    parameter int IMG_WIDTH  = c_IMG_WIDTH,
    parameter int IMG_HEIGHT = c_IMG_HEIGHT,
    parameter int KERNEL_W   = c_KERNEL_W,
    parameter int KERNEL_H   = c_KERNEL_H,
    parameter int COL_W      = cnt_width(IMG_WIDTH),
    parameter int ROW_W      = cnt_width(IMG_HEIGHT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_pix_valid,
    output logic             o_pix_ready,
    output logic             o_shift_en,
    output logic             o_win_valid,
    input  logic             i_win_ready,
    output logic [COL_W-1:0] o_win_col,
    output logic [ROW_W-1:0] o_win_row,
    output logic             o_busy,
    output logic             o_frame_done
);

    localparam logic [ROW_W-1:0] c_PRIME_LAST_ROW =
        ROW_W'((KERNEL_H >= 2) ? (KERNEL_H - 2) : 0);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic             w_last_col;
    logic             w_last_frame;

    logic             w_pix_ready;
    logic             w_shift;
    logic             w_cnt_clr;
    logic             w_frame_done;
    logic             w_col_ok;
    logic             w_eligible;

    logic             r_win_valid;
    logic [COL_W-1:0] r_win_col;
    logic [ROW_W-1:0] r_win_row;

    kernel_window_ctrl_pixel_pos_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .COL_W      (COL_W),
        .ROW_W      (ROW_W)
    ) u_pos (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (w_cnt_clr),
        .i_inc        (w_shift),
        .o_col        (w_col),
        .o_row        (w_row),
        .o_last_col   (w_last_col),
        .o_last_frame (w_last_frame)
    );

    // A one-pixel-wide kernel makes every column a window edge.
    generate
        if (KERNEL_W == 1) begin : g_col_any
            assign w_col_ok = 1'b1;
        end else begin : g_col_cmp
            localparam logic [COL_W-1:0] c_FIRST_WIN_COL = COL_W'(KERNEL_W - 1);
            assign w_col_ok = (w_col >= c_FIRST_WIN_COL);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pix_ready  = 1'b0;
        w_cnt_clr    = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = (KERNEL_H == 1) ? ST_RUN : ST_PRIME;
                end
            end
            ST_PRIME: begin
                w_pix_ready = 1'b1;
                if (i_pix_valid && w_last_col && (w_row == c_PRIME_LAST_ROW)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // Single-entry stall: hold the source only while a window waits.
                w_pix_ready = !(r_win_valid && !i_win_ready);
                if (i_pix_valid && w_pix_ready && w_last_frame) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_win_valid) begin
                    w_frame_done = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_shift    = i_pix_valid && w_pix_ready;
    assign w_eligible = w_shift && (r_state == ST_RUN) && w_col_ok;

    // A new eligible beat can only arrive when any held window is leaving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_valid <= 1'b0;
            r_win_col   <= '0;
            r_win_row   <= '0;
        end else if (w_eligible) begin
            r_win_valid <= 1'b1;
            r_win_col   <= w_col;
            r_win_row   <= w_row;
        end else if (i_win_ready) begin
            r_win_valid <= 1'b0;
        end
    end

    assign o_pix_ready  = w_pix_ready;
    assign o_shift_en   = w_shift;
    assign o_win_valid  = r_win_valid;
    assign o_win_col    = r_win_col;
    assign o_win_row    = r_win_row;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_frame_done = w_frame_done;

endmodule : kernel_window_ctrl
`default_nettype wire

// File: tb/tb_kernel_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_kernel_window_ctrl
// Description : Self-checking bench; three DUT configurations against a
//               raster-order window model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kernel_window_ctrl;

    function automatic int cfg_w(input int d);
        return (d == 0) ? 8 : (d == 1) ? 10 : 4;
    endfunction
    function automatic int cfg_h(input int d);
        return (d == 0) ? 6 : (d == 1) ? 7 : 2;
    endfunction
    function automatic int cfg_kw(input int d);
        return (d == 2) ? 1 : 3;
    endfunction
    function automatic int cfg_kh(input int d);
        return (d == 2) ? 1 : 3;
    endfunction

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_s [3];
    logic       pv      [3];
    logic       wr      [3];
    logic       pr      [3];
    logic       se      [3];
    logic       wv      [3];
    logic       bz      [3];
    logic       fd      [3];
    logic [7:0] wc      [3];
    logic [7:0] wrw     [3];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int W  = cfg_w(gi);
            localparam int H  = cfg_h(gi);
            localparam int CW = (W > 1) ? $clog2(W) : 1;
            localparam int RW = (H > 1) ? $clog2(H) : 1;
            logic [CW-1:0] c;
            logic [RW-1:0] r;
            kernel_window_ctrl #(
                .IMG_WIDTH  (W),
                .IMG_HEIGHT (H),
                .KERNEL_W   (cfg_kw(gi)),
                .KERNEL_H   (cfg_kh(gi)),
                .COL_W      (CW),
                .ROW_W      (RW)
            ) u_dut (
                .clk          (clk),
                .rst_n        (rst_n),
                .i_start      (start_s[gi]),
                .i_pix_valid  (pv[gi]),
                .o_pix_ready  (pr[gi]),
                .o_shift_en   (se[gi]),
                .o_win_valid  (wv[gi]),
                .i_win_ready  (wr[gi]),
                .o_win_col    (c),
                .o_win_row    (r),
                .o_busy       (bz[gi]),
                .o_frame_done (fd[gi])
            );
            assign wc[gi]  = 8'(c);
            assign wrw[gi] = 8'(r);
        end
    endgenerate

    int n_checks = 0;
    int n_fail   = 0;

    // Observations of the most recent frame
    int q_col[$], q_row[$];
    int e_col[$], e_row[$];
    int n_shift, n_fd, fd_cycle, last_acc, pre_win_shifts;
    int stall_pr0, stall_stable, err_se, err_idle, err_stall_pr;
    int hold_c, hold_r;
    bit timed_out;

    // Reference: every fully in-image window, bottom-right corner, raster order.
    task automatic build_model(input int d);
        e_col.delete();
        e_row.delete();
        for (int r = cfg_kh(d) - 1; r < cfg_h(d); r++)
            for (int c = cfg_kw(d) - 1; c < cfg_w(d); c++) begin
                e_col.push_back(c);
                e_row.push_back(r);
            end
    endtask

    function automatic int win_bad();
        int bad = 0;
        if (q_col.size() != e_col.size()) bad++;
        foreach (e_col[i])
            if (i >= q_col.size() || q_col[i] != e_col[i] || q_row[i] != e_row[i]) bad++;
        return bad;
    endfunction

    task automatic run_frame(input int d, input int pv_pct, input int wr_pct,
                             input int stall_len, input int start_at_shift);
        int  stall_left = 0;
        int  tail = -1;
        bit  first_seen = 0;
        bit  start_sent = 0;
        bit  stalled;
        bit  fin = 0;
        q_col.delete(); q_row.delete();
        n_shift = 0; n_fd = 0; fd_cycle = -1; last_acc = -1; pre_win_shifts = -1;
        stall_pr0 = 0; stall_stable = 0; err_se = 0; err_idle = 0; err_stall_pr = 0;
        hold_c = -1; hold_r = -1;
        @(negedge clk);
        start_s[d] = 1'b1; pv[d] = 1'b1; wr[d] = 1'b1;
        #1;
        if (pr[d] || se[d]) err_idle++;
        @(negedge clk);
        for (int k = 0; k < 6000 && !fin; k++) begin
            start_s[d] = 1'b0;
            if (start_at_shift >= 0 && !start_sent && n_shift >= start_at_shift) begin
                start_s[d] = 1'b1;
                start_sent = 1;
            end
            pv[d] = ($urandom_range(99) < pv_pct);
            if (wv[d] && !first_seen) begin
                first_seen     = 1;
                pre_win_shifts = n_shift;
                stall_left     = stall_len;
                hold_c         = wc[d];
                hold_r         = wrw[d];
            end
            stalled = 0;
            if (stall_left > 0) begin
                wr[d] = 1'b0;
                stall_left--;
                stalled = 1;
            end else begin
                wr[d] = ($urandom_range(99) < wr_pct);
            end
            #1;
            if (stalled) begin
                if (!pr[d] && !se[d]) stall_pr0++;
                if (wv[d] && wc[d] == 8'(hold_c) && wrw[d] == 8'(hold_r)) stall_stable++;
            end
            if (se[d] !== (pv[d] && pr[d])) err_se++;
            if ((!bz[d] || fd[d]) && (pr[d] || se[d])) err_idle++;
            if (wv[d] && !wr[d] && pr[d]) err_stall_pr++;
            if (se[d]) n_shift++;
            if (wv[d] && wr[d]) begin
                q_col.push_back(int'(wc[d]));
                q_row.push_back(int'(wrw[d]));
                last_acc = cyc;
            end
            if (fd[d]) begin
                n_fd++;
                fd_cycle = cyc;
            end
            if (fd[d] && tail < 0) tail = 4;
            else if (tail > 0) tail--;
            if (tail == 0) fin = 1;
            @(negedge clk);
        end
        start_s[d] = 1'b0; pv[d] = 1'b0; wr[d] = 1'b0;
        timed_out = !fin;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            start_s[d] = 1'b0; pv[d] = 1'b1; wr[d] = 1'b1;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if ({pr[d], se[d], wv[d], bz[d], fd[d], wc[d], wrw[d]} !== 21'd0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: got %h expected 0", d,
                         {pr[d], se[d], wv[d], bz[d], fd[d], wc[d], wrw[d]});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) pv[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_throughput();
        build_model(0);
        run_frame(0, 100, 100, 0, -1);
        n_checks++;
        if (timed_out) begin n_fail++; $display("FAIL full_timeout: got timeout expected frame_done"); end
        n_checks++;
        if (pre_win_shifts != 2 * 8 + 3) begin
            n_fail++; $display("FAIL full_prime_beats: got %0d expected %0d", pre_win_shifts, 2 * 8 + 3);
        end
        n_checks++;
        if (win_bad() != 0) begin
            n_fail++; $display("FAIL full_windows: got %0d windows (%0d bad) expected %0d", q_col.size(), win_bad(), e_col.size());
        end
        n_checks++;
        if (q_col.size() == 0 || q_col[0] != 2 || q_row[0] != 2) begin
            n_fail++; $display("FAIL full_first_window: got count %0d expected first at (2,2)", q_col.size());
        end
        n_checks++;
        if (n_shift != 48) begin n_fail++; $display("FAIL full_shift_count: got %0d expected 48", n_shift); end
        n_checks++;
        if (n_fd != 1 || fd_cycle - last_acc != 1) begin
            n_fail++; $display("FAIL full_frame_done: got %0d pulses gap %0d expected 1 pulse gap 1", n_fd, fd_cycle - last_acc);
        end
        n_checks++;
        if (err_se != 0 || err_idle != 0 || err_stall_pr != 0) begin
            n_fail++; $display("FAIL full_handshake: got errors %0d/%0d/%0d expected 0/0/0", err_se, err_idle, err_stall_pr);
        end
    endtask

    task automatic test_stall();
        build_model(0);
        run_frame(0, 100, 100, 5, -1);
        n_checks++;
        if (hold_c != 2 || hold_r != 2) begin
            n_fail++; $display("FAIL stall_first_coord: got (%0d,%0d) expected (2,2)", hold_c, hold_r);
        end
        n_checks++;
        if (stall_pr0 != 5) begin n_fail++; $display("FAIL stall_backpressure: got %0d cycles expected 5", stall_pr0); end
        n_checks++;
        if (stall_stable != 5) begin n_fail++; $display("FAIL stall_hold: got %0d cycles expected 5", stall_stable); end
        n_checks++;
        if (win_bad() != 0 || n_shift != 48 || timed_out) begin
            n_fail++; $display("FAIL stall_windows: got %0d windows %0d shifts expected 24 windows 48 shifts", q_col.size(), n_shift);
        end
    endtask

    task automatic test_random();
        build_model(1);
        for (int it = 0; it < 2; it++) begin
            run_frame(1, 50, 50, 0, -1);
            n_checks++;
            if (win_bad() != 0 || q_col.size() != 40) begin
                n_fail++; $display("FAIL random_windows: got %0d windows (%0d bad) expected 40", q_col.size(), win_bad());
            end
            n_checks++;
            if (n_shift != 70 || pre_win_shifts != 2 * 10 + 3) begin
                n_fail++; $display("FAIL random_shifts: got %0d/%0d expected 70/23", n_shift, pre_win_shifts);
            end
            n_checks++;
            if (n_fd != 1 || timed_out || err_se != 0 || err_stall_pr != 0 || err_idle != 0) begin
                n_fail++; $display("FAIL random_protocol: got fd %0d errs %0d/%0d/%0d expected fd 1 errs 0", n_fd, err_se, err_stall_pr, err_idle);
            end
        end
    endtask

    task automatic test_k1();
        build_model(2);
        run_frame(2, 100, 100, 0, -1);
        n_checks++;
        if (win_bad() != 0 || q_col.size() != 8) begin
            n_fail++; $display("FAIL k1_windows: got %0d windows (%0d bad) expected 8", q_col.size(), win_bad());
        end
        n_checks++;
        if (pre_win_shifts != 1 || n_shift != 8 || n_fd != 1 || timed_out) begin
            n_fail++; $display("FAIL k1_frame: got prime %0d shifts %0d fd %0d expected 1/8/1", pre_win_shifts, n_shift, n_fd);
        end
        run_frame(2, 60, 60, 0, -1);
        n_checks++;
        if (win_bad() != 0 || n_fd != 1 || timed_out) begin
            n_fail++; $display("FAIL k1_random: got %0d windows fd %0d expected 8 windows fd 1", q_col.size(), n_fd);
        end
    endtask

    task automatic test_reset_mid_run();
        int cnt = 0;
        int fd_seen = 0;
        @(negedge clk);
        start_s[0] = 1'b1; pv[0] = 1'b0; wr[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0; pv[0] = 1'b1;
        for (int k = 0; k < 200 && cnt < 28; k++) begin
            #1;
            if (se[0]) cnt++;
            if (fd[0]) fd_seen++;
            @(negedge clk);
        end
        n_checks++;
        if (!wv[0] || wc[0] != 8'd3 || wrw[0] != 8'd3) begin
            n_fail++; $display("FAIL midrun_window: got v%0d (%0d,%0d) expected v1 (3,3)", wv[0], wc[0], wrw[0]);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({pr[0], se[0], wv[0], bz[0], fd[0], wc[0], wrw[0]} !== 21'd0 || fd_seen != 0) begin
            n_fail++; $display("FAIL midrun_reset: got %h fd_seen %0d expected 0", {pr[0], se[0], wv[0], bz[0], fd[0], wc[0], wrw[0]}, fd_seen);
        end
        pv[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        build_model(0);
        run_frame(0, 80, 80, 0, -1);
        n_checks++;
        if (win_bad() != 0 || n_shift != 48 || n_fd != 1 || timed_out) begin
            n_fail++; $display("FAIL midrun_restart: got %0d windows %0d shifts fd %0d expected 24/48/1", q_col.size(), n_shift, n_fd);
        end
    endtask

    task automatic test_start_ignored();
        build_model(0);
        run_frame(0, 100, 100, 0, 30);
        n_checks++;
        if (win_bad() != 0 || n_shift != 48) begin
            n_fail++; $display("FAIL start_ignored_windows: got %0d windows %0d shifts expected 24/48", q_col.size(), n_shift);
        end
        n_checks++;
        if (n_fd != 1 || err_idle != 0 || timed_out) begin
            n_fail++; $display("FAIL start_ignored_idle: got fd %0d idle_errs %0d expected fd 1 errs 0", n_fd, err_idle);
        end
    endtask

    initial begin
        test_reset();
        test_full_throughput();
        test_stall();
        test_random();
        test_k1();
        test_reset_mid_run();
        test_start_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got time limit expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_kernel_window_ctrl
`default_nettype wire
